// File: rtl/hamming_tx_scheduler_pkg.sv
// Shared state encoding and data widths for the Hamming(7,4) transmit scheduler.
package hamming_tx_pkg;

  localparam int CODE_W   = 7;
  localparam int NIBBLE_W = 4;
  localparam int TX_W     = 8;

  typedef enum logic [2:0] {
    IDLE,
    ENC_START,
    ENC_WAIT,
    TX_START,
    TX_WAIT_BUSY,
    TX_WAIT_DONE
  } state_e;

endpackage

// File: rtl/hamming_tx_scheduler_rr_arbiter.sv
// Rotating-priority arbiter: first set request at or after ptr (mod NUM_REQ) wins.
module rr_arbiter
  import hamming_tx_pkg::*;
#(
  parameter int NUM_REQ = 4
) (
  input  logic [NUM_REQ-1:0]         req,
  input  logic [$clog2(NUM_REQ)-1:0] ptr,
  output logic [NUM_REQ-1:0]         grant,
  output logic [$clog2(NUM_REQ)-1:0] idx,
  output logic                       any
);

  localparam int IDX_W = $clog2(NUM_REQ);

  logic [IDX_W:0] pos;

  always_comb begin
    grant = '0;
    idx   = '0;
    any   = 1'b0;
    pos   = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      // one extra bit so ptr+i can be folded back for non-power-of-two NUM_REQ
      pos = {1'b0, ptr} + (IDX_W+1)'(i);
      if (pos >= (IDX_W+1)'(NUM_REQ)) pos = pos - (IDX_W+1)'(NUM_REQ);
      if (!any && req[pos[IDX_W-1:0]]) begin
        any                     = 1'b1;
        grant[pos[IDX_W-1:0]]   = 1'b1;
        idx                     = pos[IDX_W-1:0];
      end
    end
  end

endmodule

// File: rtl/hamming_tx_scheduler.sv
// Shares one Hamming(7,4) encoder and one UART transmitter among NUM_REQ nibble requesters.
// Define HAMMING_TX_SCHED_FIXED_PRIO_EN for fixed priority (lowest index wins) instead of round-robin.
//
// state        | meaning
// IDLE         | arbitrate, accept winning nibble
// ENC_START    | one-cycle encoder enable
// ENC_WAIT     | wait for enc_valid (timed)
// TX_START     | one-cycle transmitter launch
// TX_WAIT_BUSY | wait for tx_busy to rise (timed)
// TX_WAIT_DONE | wait for tx_busy to fall, then count the frame
module hamming_tx_scheduler
  import hamming_tx_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int TIMEOUT = 15
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [NUM_REQ-1:0]            req_valid,
  input  logic [NIBBLE_W*NUM_REQ-1:0]   req_data,
  output logic [NUM_REQ-1:0]            req_ready,
  output logic                          enc_start,
  output logic [NIBBLE_W-1:0]           enc_data,
  input  logic [CODE_W-1:0]             enc_code,
  input  logic                          enc_valid,
  output logic                          tx_start,
  output logic [TX_W-1:0]               tx_data,
  input  logic                          tx_busy,
  output logic [$clog2(NUM_REQ)-1:0]    grant_id,
  output logic                          active,
  output logic [7:0]                    frame_cnt,
  output logic                          err_timeout,
  input  logic                          err_clr
);

  localparam int         IDX_W     = $clog2(NUM_REQ);
  localparam logic [7:0] WAIT_LAST = 8'(TIMEOUT - 1);

  state_e             state, state_nxt;
  logic [NUM_REQ-1:0] arb_grant;
  logic [IDX_W-1:0]   arb_idx;
  logic [IDX_W-1:0]   arb_ptr;
  logic               arb_any;
  logic [CODE_W-1:0]  code_q;
  logic [7:0]         wait_cnt;
  logic               wait_expired;
  logic               frame_done;
  logic               frame_abort;

  rr_arbiter #(.NUM_REQ(NUM_REQ)) u_arb (
    .req   (req_valid),
    .ptr   (arb_ptr),
    .grant (arb_grant),
    .idx   (arb_idx),
    .any   (arb_any)
  );

`ifdef HAMMING_TX_SCHED_FIXED_PRIO_EN
  assign arb_ptr = '0;
`else
  logic [IDX_W-1:0] rr_ptr;

  always_ff @(posedge clk) begin
    if (rst) begin
      rr_ptr <= '0;
    end else if (frame_done || frame_abort) begin
      rr_ptr <= (grant_id == IDX_W'(NUM_REQ - 1)) ? '0 : grant_id + IDX_W'(1);
    end
  end

  assign arb_ptr = rr_ptr;
`endif

  assign wait_expired = (wait_cnt == WAIT_LAST);

  always_comb begin
    state_nxt   = state;
    frame_done  = 1'b0;
    frame_abort = 1'b0;
    case (state)
      IDLE:         if (arb_any) state_nxt = ENC_START;
      ENC_START:    state_nxt = ENC_WAIT;
      ENC_WAIT: begin
        if (enc_valid) begin
          state_nxt = TX_START;
        end else if (wait_expired) begin
          frame_abort = 1'b1;
          state_nxt   = IDLE;
        end
      end
      TX_START:     state_nxt = TX_WAIT_BUSY;
      TX_WAIT_BUSY: begin
        if (tx_busy) begin
          state_nxt = TX_WAIT_DONE;
        end else if (wait_expired) begin
          frame_abort = 1'b1;
          state_nxt   = IDLE;
        end
      end
      TX_WAIT_DONE: begin
        if (!tx_busy) begin
          frame_done = 1'b1;
          state_nxt  = IDLE;
        end
      end
      default:      state_nxt = IDLE;
    endcase
  end

  // ready is masked during reset so a requester is never told it was served while the FSM is held
  assign req_ready = (state == IDLE && !rst) ? arb_grant : '0;
  assign enc_start = (state == ENC_START);
  assign tx_start  = (state == TX_START);
  assign active    = (state != IDLE);
  assign tx_data   = {1'b0, code_q};

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      enc_data    <= '0;
      code_q      <= '0;
      grant_id    <= '0;
      frame_cnt   <= '0;
      err_timeout <= 1'b0;
      wait_cnt    <= '0;
    end else begin
      state <= state_nxt;
      if (state == IDLE && arb_any) begin
        enc_data <= req_data[{arb_idx, 2'b00} +: NIBBLE_W];
        grant_id <= arb_idx;
      end
      if (state == ENC_WAIT && enc_valid) code_q <= enc_code;
      if (state == ENC_START || state == TX_START) begin
        wait_cnt <= '0;
      end else if (state == ENC_WAIT || state == TX_WAIT_BUSY) begin
        wait_cnt <= wait_cnt + 8'd1;
      end
      if (frame_done) frame_cnt <= frame_cnt + 8'd1;
      if (frame_abort) begin
        err_timeout <= 1'b1;
      end else if (err_clr) begin
        err_timeout <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_hamming_tx_scheduler.sv
// Directed bench for hamming_tx_scheduler (NUM_REQ=4, TIMEOUT=15) with simple encoder/transmitter models.
module tb_hamming_tx_scheduler;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [3:0]  req_valid = '0;
  logic [15:0] req_data = '0;
  logic [3:0]  req_ready;
  logic        enc_start;
  logic [3:0]  enc_data;
  logic [6:0]  enc_code = 7'h55;
  logic        enc_valid = 1'b0;
  logic        tx_start;
  logic [7:0]  tx_data;
  logic        tx_busy = 1'b0;
  logic [1:0]  grant_id;
  logic        active;
  logic [7:0]  frame_cnt;
  logic        err_timeout;
  logic        err_clr = 1'b0;

  int errors = 0;
  int checks = 0;

  logic enc_resp_en = 1'b1;
  logic tx_resp_en  = 1'b1;
  int   tx_len      = 2;
  int   tx_cnt      = 0;
  int   tx_starts   = 0;

  always #5 clk = ~clk;

  hamming_tx_scheduler dut (
    .clk         (clk),
    .rst         (rst),
    .req_valid   (req_valid),
    .req_data    (req_data),
    .req_ready   (req_ready),
    .enc_start   (enc_start),
    .enc_data    (enc_data),
    .enc_code    (enc_code),
    .enc_valid   (enc_valid),
    .tx_start    (tx_start),
    .tx_data     (tx_data),
    .tx_busy     (tx_busy),
    .grant_id    (grant_id),
    .active      (active),
    .frame_cnt   (frame_cnt),
    .err_timeout (err_timeout),
    .err_clr     (err_clr)
  );

  // encoder answers one cycle after enc_start; transmitter is busy for tx_len cycles after tx_start
  always @(posedge clk) begin
    enc_valid <= enc_resp_en && enc_start;
    if (tx_start) tx_starts <= tx_starts + 1;
    if (tx_resp_en && tx_start) begin
      tx_busy <= 1'b1;
      tx_cnt  <= tx_len;
    end else if (tx_cnt > 1) begin
      tx_cnt <= tx_cnt - 1;
    end else begin
      tx_busy <= 1'b0;
      tx_cnt  <= 0;
    end
  end

  task automatic cyc();
    @(negedge clk);
    #1;
  endtask

  task automatic wait_idle(input string tag, input int max);
    int n;
    n = 0;
    while (active !== 1'b0 && n < max) begin
      cyc();
      n++;
    end
    checks++; if (active !== 1'b0) begin errors++; $display("FAIL %s_idle: active=%b after %0d cycles, expected 0", tag, active, n); end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) cyc();
    checks++; if ({req_ready, enc_start, tx_start, active, err_timeout} !== 8'h00) begin errors++; $display("FAIL reset_ctrl: got %b expected 0", {req_ready, enc_start, tx_start, active, err_timeout}); end
    checks++; if ({enc_data, tx_data, grant_id, frame_cnt} !== 22'h0) begin errors++; $display("FAIL reset_regs: got %h expected 0", {enc_data, tx_data, grant_id, frame_cnt}); end
    rst = 1'b0;
  endtask

  task automatic test_single();
    cyc();
    req_data  = 16'h0B00;
    req_valid = 4'b0100;
    #1;
    checks++; if (req_ready !== 4'b0100) begin errors++; $display("FAIL single_ready: got %b expected 0100", req_ready); end
    cyc();
    req_valid = 4'b0000;
    checks++; if ({enc_start, enc_data, grant_id} !== {1'b1, 4'hB, 2'd2}) begin errors++; $display("FAIL single_enc_start: got start=%b data=%h id=%0d expected 1 b 2", enc_start, enc_data, grant_id); end
    cyc();
    checks++; if ({enc_start, tx_start} !== 2'b00) begin errors++; $display("FAIL single_cycle2: got enc_start=%b tx_start=%b expected 0 0", enc_start, tx_start); end
    cyc();
    checks++; if ({tx_start, tx_data} !== {1'b1, 8'h55}) begin errors++; $display("FAIL single_tx_start: got start=%b data=%h expected 1 55", tx_start, tx_data); end
    cyc();
    checks++; if (tx_start !== 1'b0) begin errors++; $display("FAIL single_tx_pulse: got %b expected 0", tx_start); end
    wait_idle("single", 20);
    checks++; if (frame_cnt !== 8'd1) begin errors++; $display("FAIL single_frame_cnt: got %0d expected 1", frame_cnt); end
  endtask

  task automatic test_round_robin();
    int n;
    int exp_id;
    logic [3:0] exp_oh;
    logic [3:0] exp_nib;
    rst = 1'b1;
    cyc();
    cyc();
    rst       = 1'b0;
    req_data  = 16'h7C3A;
    req_valid = 4'b1111;
    #1;
    for (int k = 0; k < 5; k++) begin
`ifdef HAMMING_TX_SCHED_FIXED_PRIO_EN
      exp_id = 0;
`else
      exp_id = k % 4;
`endif
      exp_oh  = 4'b0001 << exp_id;
      exp_nib = 4'(req_data >> (4 * exp_id));
      n = 0;
      while (req_ready === 4'b0000 && n < 30) begin
        cyc();
        n++;
      end
      checks++; if (req_ready !== exp_oh) begin errors++; $display("FAIL rr_ready_%0d: got %b expected %b", k, req_ready, exp_oh); end
      cyc();
      checks++; if ({grant_id, enc_data} !== {2'(exp_id), exp_nib}) begin errors++; $display("FAIL rr_grant_%0d: got id=%0d data=%h expected id=%0d data=%h", k, grant_id, enc_data, exp_id, exp_nib); end
    end
    req_valid = 4'b0000;
    wait_idle("rr", 30);
    checks++; if (frame_cnt !== 8'd5) begin errors++; $display("FAIL rr_frame_cnt: got %0d expected 5", frame_cnt); end
  endtask

  task automatic test_enc_timeout();
    int starts0;
    logic [7:0] fc0;
    enc_resp_en = 1'b0;
    starts0     = tx_starts;
    fc0         = frame_cnt;
    req_data    = 16'h0050;
    req_valid   = 4'b0010;
    #1;
    checks++; if (req_ready !== 4'b0010) begin errors++; $display("FAIL enc_to_ready: got %b expected 0010", req_ready); end
    cyc();
    req_valid = 4'b0000;
    repeat (15) cyc();
    checks++; if ({active, err_timeout} !== 2'b10) begin errors++; $display("FAIL enc_to_early: got active=%b err=%b expected 1 0", active, err_timeout); end
    cyc();
    checks++; if ({active, err_timeout} !== 2'b01) begin errors++; $display("FAIL enc_to_abort: got active=%b err=%b expected 0 1", active, err_timeout); end
    checks++; if (tx_starts !== starts0) begin errors++; $display("FAIL enc_to_no_tx: got %0d tx_start pulses expected %0d", tx_starts, starts0); end
    checks++; if (frame_cnt !== fc0) begin errors++; $display("FAIL enc_to_frame_cnt: got %0d expected %0d", frame_cnt, fc0); end
    err_clr = 1'b1;
    cyc();
    err_clr = 1'b0;
    checks++; if (err_timeout !== 1'b0) begin errors++; $display("FAIL enc_to_clear: got %b expected 0", err_timeout); end
    enc_resp_en = 1'b1;
  endtask

  task automatic test_tx_timeout();
    int starts0;
    int id0;
    int id1;
    logic [7:0] fc0;
`ifdef HAMMING_TX_SCHED_FIXED_PRIO_EN
    id0 = 0;
    id1 = 0;
`else
    id0 = 2;
    id1 = 3;
`endif
    tx_resp_en = 1'b0;
    err_clr    = 1'b1;
    starts0    = tx_starts;
    fc0        = frame_cnt;
    req_data   = 16'h9876;
    req_valid  = 4'b1111;
    #1;
    checks++; if (req_ready !== 4'(1 << id0)) begin errors++; $display("FAIL tx_to_ready: got %b expected %b", req_ready, 4'(1 << id0)); end
    repeat (18) cyc();
    checks++; if ({active, err_timeout} !== 2'b10) begin errors++; $display("FAIL tx_to_early: got active=%b err=%b expected 1 0", active, err_timeout); end
    cyc();
    checks++; if ({active, err_timeout} !== 2'b01) begin errors++; $display("FAIL tx_to_abort_set_wins: got active=%b err=%b expected 0 1", active, err_timeout); end
    checks++; if (tx_starts !== starts0 + 1) begin errors++; $display("FAIL tx_to_one_launch: got %0d expected %0d", tx_starts, starts0 + 1); end
    checks++; if (frame_cnt !== fc0) begin errors++; $display("FAIL tx_to_frame_cnt: got %0d expected %0d", frame_cnt, fc0); end
    checks++; if (req_ready !== 4'(1 << id1)) begin errors++; $display("FAIL tx_to_next_grant: got %b expected %b", req_ready, 4'(1 << id1)); end
    req_valid = 4'b0000;
    err_clr   = 1'b0;
    cyc();
    checks++; if (err_timeout !== 1'b1) begin errors++; $display("FAIL tx_to_sticky: got %b expected 1", err_timeout); end
    err_clr = 1'b1;
    cyc();
    err_clr = 1'b0;
    checks++; if (err_timeout !== 1'b0) begin errors++; $display("FAIL tx_to_clear: got %b expected 0", err_timeout); end
    tx_resp_en = 1'b1;
  endtask

  task automatic test_reset_mid_frame();
    tx_len    = 6;
    req_data  = 16'h00E0;
    req_valid = 4'b0010;
    cyc();
    req_valid = 4'b0000;
    repeat (5) cyc();
    checks++; if ({active, tx_busy} !== 2'b11) begin errors++; $display("FAIL rstmid_in_flight: got active=%b busy=%b expected 1 1", active, tx_busy); end
    rst       = 1'b1;
    req_data  = 16'h4000;
    req_valid = 4'b1000;
    cyc();
    checks++; if ({req_ready, enc_start, tx_start, active, err_timeout} !== 8'h00) begin errors++; $display("FAIL rstmid_ctrl: got %b expected 0", {req_ready, enc_start, tx_start, active, err_timeout}); end
    checks++; if ({enc_data, tx_data, grant_id, frame_cnt} !== 22'h0) begin errors++; $display("FAIL rstmid_regs: got %h expected 0", {enc_data, tx_data, grant_id, frame_cnt}); end
    cyc();
    rst = 1'b0;
    #1;
    checks++; if (req_ready !== 4'b1000) begin errors++; $display("FAIL rstmid_ready: got %b expected 1000", req_ready); end
    cyc();
    req_valid = 4'b0000;
    checks++; if ({enc_start, grant_id, enc_data} !== {1'b1, 2'd3, 4'h4}) begin errors++; $display("FAIL rstmid_grant: got start=%b id=%0d data=%h expected 1 3 4", enc_start, grant_id, enc_data); end
    wait_idle("rstmid", 40);
    checks++; if (frame_cnt !== 8'd1) begin errors++; $display("FAIL rstmid_frame_cnt: got %0d expected 1", frame_cnt); end
    tx_len = 2;
  endtask

  task automatic test_wrap();
    int n;
    int idles;
    tx_len = 1;
    rst    = 1'b1;
    cyc();
    cyc();
    req_data  = 16'h0001;
    req_valid = 4'b0001;
    rst       = 1'b0;
    #1;
    n     = 0;
    idles = 0;
    while (idles < 257 && n < 4000) begin
      if (active === 1'b0) begin
        idles++;
        if (idles == 256) begin
          checks++; if (frame_cnt !== 8'd255) begin errors++; $display("FAIL wrap_255: got %0d expected 255", frame_cnt); end
        end
        if (idles == 257) begin
          req_valid = 4'b0000;
          checks++; if (frame_cnt !== 8'd0) begin errors++; $display("FAIL wrap_0: got %0d expected 0", frame_cnt); end
        end
      end
      if (idles < 257) cyc();
      n++;
    end
    checks++; if (idles != 257) begin errors++; $display("FAIL wrap_bound: got %0d idle cycles expected 257", idles); end
    req_valid = 4'b0000;
    tx_len    = 2;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_single();
    test_round_robin();
    test_enc_timeout();
    test_tx_timeout();
    test_reset_mid_frame();
    test_wrap();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/hamming_tx_scheduler.md
# hamming_tx_scheduler

Round-robin scheduler sharing one Hamming(7,4) encoder and one UART transmitter among NUM_REQ nibble requesters. It accepts a 4-bit word from the winning requester and drives the encoder. It captures the 7-bit code, launches the transmitter with a one-cycle start pulse and holds the grant until the frame completes. It sits between the user-side request ports and the existing encoder/transmitter pair in the top level.

## Interface
- NUM_REQ, default 4: number of requesters, 2..8
- TIMEOUT, default 15: maximum cycles spent waiting for enc_valid, or for tx_busy to rise, before the frame is aborted; range 1..255

Ports (direction, width, meaning):
- clk, in, 1: single clock, rising edge
- rst, in, 1: synchronous, active-high reset
- req_valid, in, NUM_REQ: per-requester request; held with data until its ready
- req_data, in, 4*NUM_REQ: nibble i occupies bits [4i+3:4i]
- req_ready, out, NUM_REQ: one-hot accept strobe; combinational
- enc_start, out, 1: one-cycle encoder enable
- enc_data, out, 4: nibble presented to the encoder
- enc_code, in, 7: encoder result
- enc_valid, in, 1: encoder result valid
- tx_start, out, 1: one-cycle transmitter launch
- tx_data, out, 8: {1'b0, captured code}
- tx_busy, in, 1: transmitter busy
- grant_id, out, $clog2(NUM_REQ): index of the current or last owner
- active, out, 1: high in every state except IDLE
- frame_cnt, out, 8: completed frames; wraps 255→0
- err_timeout, out, 1: sticky abort flag
- err_clr, in, 1: clears err_timeout

## Operation
- FSM states: IDLE, ENC_START, ENC_WAIT, TX_START, TX_WAIT_BUSY, TX_WAIT_DONE.
- **IDLE**
  - Winner = first requester with req_valid set, searching rr_ptr, rr_ptr+1, … (mod NUM_REQ).
  - req_ready[winner]=1 in the same cycle. req_ready is all-zero in every other state.
  - On that edge: capture the nibble into enc_data and the index into grant_id, then go to ENC_START.
- **ENC_START**: enc_start=1 for exactly one cycle, then go to ENC_WAIT.
- **ENC_WAIT**
  - On enc_valid: capture enc_code into tx_data[6:0] and go to TX_START.
  - enc_valid is ignored in every state except ENC_WAIT.
- **TX_START**: tx_start=1 for exactly one cycle, then go to TX_WAIT_BUSY.
- **TX_WAIT_BUSY**: on tx_busy=1, go to TX_WAIT_DONE.
- **TX_WAIT_DONE**: on tx_busy=0:
  - frame_cnt += 1;
  - rr_ptr = grant_id+1 (mod NUM_REQ);
  - go to IDLE.
- **Timeout**
  - One 8-bit wait counter is cleared on entry to ENC_WAIT and to TX_WAIT_BUSY, and increments each cycle spent in either state.
  - When it reaches TIMEOUT with no exit condition: set err_timeout, advance rr_ptr as on completion, go to IDLE. frame_cnt is not incremented.
- **Error flag**: err_clr clears err_timeout. If a set and a clear occur in the same cycle, set wins.
- **Outputs**: enc_start, tx_start, req_ready and active are decoded from the state register. enc_data, tx_data, grant_id and frame_cnt are registers.
- **Reset**: any state goes to IDLE, and every output is 0:
  - tx_data=8'h00, enc_data=0, grant_id=0, frame_cnt=0, err_timeout=0;
  - rr_ptr=0;
  - a frame in flight is abandoned and no pulse is emitted.

## Timing
- Cycle 0: IDLE with req_valid; req_ready high.
- Cycle 1: enc_start high.
- With an encoder whose enc_valid arrives in cycle 2: tx_start high in cycle 3.
- Minimum IDLE-to-launch latency is 3 cycles.
- The first new grant comes one cycle after tx_busy falls; back-to-back frames need at least one IDLE cycle.
- tx_data is stable from TX_START until the next capture.
- A request deasserted before its ready is simply not served; no state is kept.
- Simultaneous requests are serialized in round-robin order.

## Configuration
- HAMMING_TX_SCHED_FIXED_PRIO_EN
  - Defined: fixed priority; lowest index wins; rr_ptr is neither implemented nor updated.
  - Undefined (default): round-robin as above.

## Structure
- Package hamming_tx_pkg holds:
  - the state enum;
  - the constants CODE_W=7, NIBBLE_W=4, TX_W=8.
- One sub-module, rr_arbiter: parameterised NUM_REQ; takes the request vector and pointer and returns a one-hot grant plus index. The fixed-priority build instantiates it with the pointer tied to 0.

## Test plan
- Single request, 1-cycle encoder model:
  - Stimulus: req_valid[2]=1, req_data nibble 2=4'hB, model returns 7'h55.
  - Required: req_ready=4'b0100 in cycle 0, enc_start in cycle 1 with enc_data=4'hB, tx_start in cycle 3 with tx_data=8'h55.
  - After tx_busy pulses high then low: frame_cnt=1, active=0.
- All four requests held:
  - Required: grants 0,1,2,3,0 in that order.
  - Under HAMMING_TX_SCHED_FIXED_PRIO_EN, with req0 re-asserted every frame: req0 always wins.
- Encoder never asserts enc_valid, TIMEOUT=15:
  - Required: err_timeout=1 after 15 cycles in ENC_WAIT, return to IDLE, no tx_start, frame_cnt unchanged.
  - Then err_clr=1: err_timeout=0.
- tx_busy never rises:
  - Required: timeout from TX_WAIT_BUSY; the next grant goes to grant_id+1.
- rst=1 during TX_WAIT_DONE:
  - Required next cycle: all outputs 0, state IDLE, rr_ptr=0; a held req_valid[3] is granted one cycle after rst falls.
- frame_cnt wrap:
  - Stimulus: 256 completed frames.
  - Required: frame_cnt=0.
